ah_func_sched: RTL and testbench

Issue scheduler and result buffer for the fixed-latency pipelined `ah_func_instr` floating-point function unit (FU). It accepts operand pairs on a valid/ready stream and issues at most one to the FU per cycle. It tracks in-flight operations with a valid-tag pipeline, because the FU itself has no valid or stall signals. Results are captured into a credit-protected FIFO, so downstream backpressure never loses an FU result. It sits between the host/custom-instruction front end and the FU instance.

---
 rtl/ah_func_pkg.sv | 7 +
 rtl/ah_sync_fifo.sv | 80 ++++++++
 rtl/ah_func_sched.sv | 92 +++++++++
 tb/tb_ah_func_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ah_func_pkg.sv
// Shared types and constants for the ah_func issue scheduler and its FU.
package ah_func_pkg;
  localparam int FP_W            = 32;
  localparam int AH_FUNC_LATENCY = 64;

  typedef logic [FP_W-1:0] fp32_t;
endpackage

// File: rtl/ah_sync_fifo.sv
// In-order synchronous FIFO with a registered head word. A write into an
// empty FIFO becomes visible on the head one cycle later (no write-through).
module ah_sync_fifo
  import ah_func_pkg::*;
#(
  parameter int WIDTH = FP_W,
  parameter int DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_fire, head_from_wr, head_from_mem, mem_wr;

  // Entries behind the head live in mem_q; the head is refilled from mem_q
  // when popped, or straight from the write port when nothing is queued.
  always_comb begin
    rd_fire       = rd_en_i && (count_q != '0);
    head_from_wr  = wr_en_i && ((count_q == '0) || ((count_q == ONE_C) && rd_fire));
    head_from_mem = rd_fire && (count_q > ONE_C);
    mem_wr        = wr_en_i && !head_from_wr;
    wr_ptr_d      = mem_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = head_from_mem ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    if (wr_en_i && !rd_fire) begin
      count_d = count_q + ONE_C;
    end else if (!wr_en_i && rd_fire) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (head_from_mem) begin
        head_q <= mem_q[rd_ptr_q];
      end else if (head_from_wr) begin
        head_q <= wr_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(wr_en_i && (count_q == FULL_C) && !rd_fire));
    end
  end

  assign rd_data_o = head_q;
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;
endmodule

// File: rtl/ah_func_sched.sv
// Issue scheduler for the fixed-latency ah_func_instr FU: tracks in-flight
// ops with a tag pipeline and reserves result FIFO space with a credit count.
module ah_func_sched
  import ah_func_pkg::*;
#(
  parameter int LATENCY    = AH_FUNC_LATENCY,
  parameter int FIFO_DEPTH = 128
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  fp32_t dataa,
  input  fp32_t datab,
  output logic  out_valid,
  input  logic  out_ready,
  output fp32_t result,
  output fp32_t fu_dataa,
  output fp32_t fu_datab,
  input  fp32_t fu_result
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] ONE_C   = OCC_W'(1);

  logic             reset_n_q;
  logic [LATENCY:0] tag_q, tag_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  fp32_t            fu_dataa_q, fu_datab_q;
  logic             accept, pop;
  logic [OCC_W-1:0] fifo_count;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  // A pop in the same cycle frees a credit, so a full scheduler can still accept.
  assign in_ready = reset_n_q && ((occ_q < DEPTH_C) || pop);

  assign tag_d[0] = accept;
  for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_tag
    assign tag_d[gi] = tag_q[gi-1];
  end

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + ONE_C;
      2'b01:   occ_d = occ_q - ONE_C;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reset_n_q  <= 1'b0;
      tag_q      <= '0;
      occ_q      <= '0;
      fu_dataa_q <= '0;
      fu_datab_q <= '0;
    end else begin
      reset_n_q <= 1'b1;
      tag_q     <= tag_d;
      occ_q     <= occ_d;
      if (accept) begin
        fu_dataa_q <= dataa;
        fu_datab_q <= datab;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n_q) begin
      assert (fifo_count <= occ_q);
    end
  end

  assign fu_dataa = fu_dataa_q;
  assign fu_datab = fu_datab_q;

  ah_sync_fifo #(
    .WIDTH (FP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (tag_q[LATENCY]),
    .wr_data_i (fu_result),
    .rd_en_i   (out_ready),
    .rd_data_o (result),
    .valid_o   (out_valid),
    .count_o   (fifo_count)
  );
endmodule

// File: tb/tb_ah_func_sched.sv
// Scoreboard bench for ah_func_sched with a behavioural 64-cycle FU model.
module tb_ah_func_sched;
  import ah_func_pkg::*;

  localparam int LAT   = 64;
  localparam int DEPTH = 128;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  in_valid;
  logic  in_ready;
  fp32_t dataa, datab;
  logic  out_valid;
  logic  out_ready;
  fp32_t result;
  fp32_t fu_dataa, fu_datab;
  fp32_t fu_result;

  always #5 clk = ~clk;

  ah_func_sched #(
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataa     (dataa),
    .datab     (datab),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .fu_dataa  (fu_dataa),
    .fu_datab  (fu_datab),
    .fu_result (fu_result)
  );

  // Stand-in for the FU function: known vectors, otherwise a fixed mixing hash.
  function automatic logic [31:0] fu_f(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3f800000 && b == 32'h00000000) return 32'h3faac7d5;
    if (a == 32'h40000000 && b == 32'h3faac7d5) return 32'h40b579ca;
    return (a * 32'h9e3779b1) ^ {b[15:0], b[31:16]} ^ 32'h01234567;
  endfunction

  logic [31:0] fu_pipe [LAT];
  always @(posedge clk) begin
    fu_pipe[0] <= fu_f(fu_dataa, fu_datab);
    for (int i = 1; i < LAT; i++) fu_pipe[i] <= fu_pipe[i-1];
  end
  assign fu_result = fu_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q [$];
  int pops = 0;
  int accepts = 0;
  int mon_checks = 0;
  int mon_pass = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Monitor: handshakes are sampled mid-cycle and take effect at the next edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops = pops + 1;
        mon_checks = mon_checks + 1;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pop: got %h, required no result", result);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (result === e) mon_pass = mon_pass + 1;
          else $display("FAIL result_order: got %h, required %h (pop %0d)", result, e, pops);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(fu_f(dataa, datab));
        accepts = accepts + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    repeat (2) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a8 [8];
    logic [31:0] b8 [8];
    logic [31:0] e8 [8];
    int t0, acc, p0, a0, bad;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dataa = '0; datab = '0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fu_dataa", fu_dataa, 32'd0);
    chk("rst_fu_datab", fu_datab, 32'd0);
    chk("rst_result", result, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("in_ready_before_sampled", 32'(in_ready), 32'd0);
    tick();
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Single op latency and pulse width
    out_ready = 1'b1;
    in_valid = 1'b1; dataa = 32'h3f800000; datab = 32'h0;
    tick();
    t0 = cyc;
    in_valid = 1'b0;
    wait_valid("single_seen");
    chk("single_latency", 32'(cyc + 1 - t0), 32'd66);
    chk("single_result", result, 32'h3faac7d5);
    @(negedge clk);
    chk("single_pulse", 32'(out_valid), 32'd0);
    tick();

    // Back-to-back stream of 8 chained pairs
    for (int i = 0; i < 8; i++) a8[i] = 32'h3f800000;
    a8[1] = 32'h40000000; a8[2] = 32'h40400000; a8[3] = 32'h40800000;
    a8[4] = 32'h40a00000; a8[5] = 32'h40c00000; a8[6] = 32'h40e00000;
    a8[7] = 32'h41000000;
    b8[0] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      e8[i] = fu_f(a8[i], b8[i]);
      if (i < 7) b8[i+1] = e8[i];
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; dataa = a8[i]; datab = b8[i];
      tick();
    end
    in_valid = 1'b0;
    wait_valid("b2b_seen");
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b_result_%0d", i), result, e8[i]);
      if (i == 0) chk("b2b_first", result, 32'h3faac7d5);
      if (i == 1) chk("b2b_second", result, 32'h40b579ca);
    end
    tick();
    drain(50);

    // Backpressure: fill all credits, then swap one accept for one pop
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 300; k++) begin
      in_valid = 1'b1; dataa = $urandom; datab = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      tick();
    end
    chk("bp_accepts", 32'(acc), 32'd128);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_on_pop", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("bp_occ_stays_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    p0 = pops;
    drain(400);
    chk("bp_drained", 32'(pops - p0), 32'd128);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random traffic, 2000 ops
    a0 = accepts;
    p0 = pops;
    for (int k = 0; k < 20000 && accepts < a0 + 2000; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      dataa = $urandom; datab = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    chk("rand_accepts", 32'(accepts - a0), 32'd2000);
    out_ready = 1'b1;
    drain(400);
    chk("rand_pops", 32'(pops - p0), 32'd2000);
    chk("rand_no_drops", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a 10-op burst
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; dataa = $urandom; datab = $urandom;
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < LAT + 12; k++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("rst_no_stale", 32'(bad), 32'd0);
    tick();
    p0 = pops;
    in_valid = 1'b1; dataa = 32'h3f800000; datab = 32'h0;
    tick();
    in_valid = 1'b0;
    repeat (90) tick();
    chk("rst_next_single", 32'(pops - p0), 32'd1);
    chk("rst_queue_empty", 32'(exp_q.size()), 32'd0);

    n_checks = n_checks + mon_checks;
    n_pass   = n_pass + mon_pass;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
